fir_coeff_loader: RTL and testbench
===================================

// Module: fir_coeff_loader
// PURPOSE
//  Produces the packed coefficient bus consumed by the FIR tap stage.
//  - Accepts coefficients one word at a time over a valid/ready stream into a shadow bank.
//  - After a full set has loaded, commits it atomically to the active bus on a sample strobe,
//    so the filter never sees a half-updated mix of old and new taps.
//  - Sits between the control/register interface and the filter.
// PARAMETERS
//  N            4   number of taps; packed bus width is COEFF_WIDTH*N
//  COEFF_WIDTH  8   signed coefficient width
//  RESET_TAP0   1   reset value of h[0]; h[1..N-1] reset to 0 (pass-through)
// PORTS
//  clk            in   1              clock, rising edge
//  rst            in   1              asynchronous reset, active-high
//  start          in   1              pulse: begin (or restart) a coefficient load
//  coeff_in       in   COEFF_WIDTH    signed coefficient word
//  coeff_valid    in   1              coeff_in is valid
//  coeff_ready    out  1              loader accepts coeff_in this cycle
//  sample_stb     in   1              filter sample boundary; commit only happens here
//  packed_coeffs  out  COEFF_WIDTH*N  active coefficients, h[t] at bits [COEFF_WIDTH*t +: COEFF_WIDTH]
//  busy           out  1              high in LOAD or COMMIT
//  load_done      out  1              one-cycle pulse when the new set becomes active
//  load_aborted   out  1              one-cycle pulse when start restarts an unfinished load
// BEHAVIOUR
//  Reset (async, rst=1)
//   - state=IDLE, idx=0, shadow all zero.
//   - packed_coeffs = {0,...,0,RESET_TAP0}.
//   - coeff_ready, busy, load_done, load_aborted = 0.
//  Transfer and ordering
//   - A transfer occurs when coeff_valid && coeff_ready at a rising edge.
//   - The k-th word accepted since start is written to shadow h[k] (first word goes to h[0]).
//  LOAD_COUNT
//   - Equals N normally; (N+1)/2 with the optional feature (see CONFIGURATION).
//   - idx counts 0..LOAD_COUNT-1, width clog2(N)+1.
//  State machine
//   - IDLE: coeff_ready=0. start -> LOAD, idx<=0.
//   - LOAD: coeff_ready=1.
//     - On a transfer: write shadow[idx], idx<=idx+1.
//     - The transfer with idx==LOAD_COUNT-1 -> COMMIT; coeff_ready drops the next cycle.
//     - start in LOAD (with or without a simultaneous transfer):
//       - idx<=0, the transfer is discarded, load_aborted pulses, stay in LOAD.
//       - Shadow contents are stale but never reach the bus.
//   - COMMIT: coeff_ready=0.
//     - On sample_stb: packed_coeffs<=shadow, load_done=1 for that cycle, -> IDLE.
//     - load_done and the new packed_coeffs are registered, visible the cycle after the strobe edge.
//     - start in COMMIT is ignored; the pending commit proceeds.
//     - sample_stb already high on COMMIT entry commits on the next edge (minimum 1 cycle in COMMIT).
//  Latency
//   - Last accepted word to new packed_coeffs: 1 cycle plus the wait for sample_stb.
//  Stability
//   - packed_coeffs changes only at a commit or at reset. It never changes during LOAD.
//   - sample_stb outside COMMIT has no effect.
//  Reset mid-load
//   - Partial shadow is discarded; the bus returns to the reset value.
//  Width
//   - Coefficients are stored verbatim; no sign extension or saturation.
// CONFIGURATION
//  FIR_COEFF_SYMMETRIC_EN defined
//   - LOAD_COUNT=(N+1)/2.
//   - Each transfer writes both shadow h[idx] and h[N-1-idx], which coincide for the middle tap of odd N.
//   - The result is a linear-phase, symmetric set.
//  FIR_COEFF_SYMMETRIC_EN undefined
//   - LOAD_COUNT=N; each word is written to one tap only.
// TESTING
//  1. Reset, N=4, W=8: packed_coeffs==32'h00000001, busy=0, coeff_ready=0.
//  2. start; stream 8'h10,8'h20,8'hF0,8'h7F back-to-back; sample_stb 3 cycles later:
//     - packed_coeffs==32'h7FF02010 only after the strobe; load_done pulses once.
//  3. start; send 2 words; start again; send 4 words 01..04; strobe:
//     - load_aborted pulses once; packed_coeffs==32'h04030201.
//  4. coeff_valid toggling 1/0 every cycle during LOAD:
//     - exactly 4 transfers; bus unchanged until the strobe; start in COMMIT is ignored.
//  5. rst asserted after 2 words:
//     - immediate return to 32'h00000001 and IDLE; a later full load commits normally.
//  6. FIR_COEFF_SYMMETRIC_EN, N=5: send 11,22,33; strobe:
//     - packed_coeffs==40'h1122332211; coeff_ready low after the 3rd word.

Source files
------------

// File: rtl/fir_coeff_loader.sv
// rtl/fir_coeff_loader.sv - streams FIR coefficients into a shadow bank and commits them atomically on a sample strobe
// Optional feature macro: FIR_COEFF_SYMMETRIC_EN (load (N+1)/2 words, each mirrored to h[N-1-idx])
module fir_coeff_loader #(
    parameter int N           = 4,
    parameter int COEFF_WIDTH = 8,
    parameter int RESET_TAP0  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [COEFF_WIDTH-1:0]   coeff_in,
    input  logic                     coeff_valid,
    output logic                     coeff_ready,
    input  logic                     sample_stb,
    output logic [COEFF_WIDTH*N-1:0] packed_coeffs,
    output logic                     busy,
    output logic                     load_done,
    output logic                     load_aborted
);

    localparam int IDX_W = $clog2(N) + 1;
`ifdef FIR_COEFF_SYMMETRIC_EN
    localparam int LOAD_COUNT = (N + 1) / 2;
`else
    localparam int LOAD_COUNT = N;
`endif
    localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(LOAD_COUNT - 1);
    localparam logic [COEFF_WIDTH-1:0]   TAP0      = COEFF_WIDTH'(RESET_TAP0);
    localparam logic [COEFF_WIDTH*N-1:0] RESET_BUS = {{(COEFF_WIDTH*(N-1)){1'b0}}, TAP0};

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } state_t;

    state_t                   state;
    logic [IDX_W-1:0]         idx;
    logic [COEFF_WIDTH*N-1:0] shadow;
    logic [N-1:0]             tap_sel;

    // One-hot tap enables for the current word; the mirror tap is also hit in symmetric mode
    always_comb begin
        tap_sel = '0;
        for (int t = 0; t < N; t++) begin
            if (idx == IDX_W'(t)) tap_sel[t] = 1'b1;
`ifdef FIR_COEFF_SYMMETRIC_EN
            if (idx == IDX_W'(N - 1 - t)) tap_sel[t] = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            shadow        <= '0;
            packed_coeffs <= RESET_BUS;
            coeff_ready   <= 1'b0;
            busy          <= 1'b0;
            load_done     <= 1'b0;
            load_aborted  <= 1'b0;
        end else begin
            load_done    <= 1'b0;
            load_aborted <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= LOAD;
                        idx         <= '0;
                        coeff_ready <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                LOAD: begin
                    // A restart wins over a simultaneous transfer; stale shadow words are overwritten later
                    if (start) begin
                        idx          <= '0;
                        load_aborted <= 1'b1;
                    end else if (coeff_valid && coeff_ready) begin
                        for (int t = 0; t < N; t++) begin
                            if (tap_sel[t]) shadow[COEFF_WIDTH*t +: COEFF_WIDTH] <= coeff_in;
                        end
                        idx <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            state       <= COMMIT;
                            coeff_ready <= 1'b0;
                        end
                    end
                end
                COMMIT: begin
                    if (sample_stb) begin
                        packed_coeffs <= shadow;
                        load_done     <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb/tb_fir_coeff_loader.sv - randomized self-checking bench for fir_coeff_loader against a word-list model
module tb_fir_coeff_loader;

    localparam int N = 4;
    localparam int W = 8;
`ifdef FIR_COEFF_SYMMETRIC_EN
    localparam int LC = (N + 1) / 2;
`else
    localparam int LC = N;
`endif
    localparam logic [W*N-1:0] RESET_BUS = 32'h0000_0001;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   coeff_in;
    logic           coeff_valid;
    logic           coeff_ready;
    logic           sample_stb;
    logic [W*N-1:0] packed_coeffs;
    logic           busy;
    logic           load_done;
    logic           load_aborted;

    int passed = 0;
    int total  = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    logic [W*N-1:0] exp_bus;

    fir_coeff_loader #(.N(N), .COEFF_WIDTH(W), .RESET_TAP0(1)) dut (
        .clk(clk), .rst(rst), .start(start), .coeff_in(coeff_in),
        .coeff_valid(coeff_valid), .coeff_ready(coeff_ready), .sample_stb(sample_stb),
        .packed_coeffs(packed_coeffs), .busy(busy), .load_done(load_done),
        .load_aborted(load_aborted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_done)    done_cnt++;
        if (load_aborted) abort_cnt++;
    end

    // Reference: word k of the accepted list lands on tap k (and on its mirror when symmetric)
    function automatic logic [W*N-1:0] build_bus(input logic [W-1:0] ws[$]);
        logic [W*N-1:0] b = '0;
        for (int k = 0; k < ws.size(); k++) begin
            b[W*k +: W] = ws[k];
`ifdef FIR_COEFF_SYMMETRIC_EN
            b[W*(N-1-k) +: W] = ws[k];
`endif
        end
        return b;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // mode 0: valid every cycle, 1: valid toggles, 2: random valid; hold_stb keeps sample_stb high
    task automatic load_words(input logic [W-1:0] ws[$], input int mode, input bit hold_stb);
        int k = 0;
        int cyc = 0;
        bit v;
        while (k < ws.size() && cyc < 200) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            coeff_valid = v;
            coeff_in    = v ? ws[k] : W'($urandom);
            sample_stb  = hold_stb ? 1'b1 : 1'($urandom_range(0, 1));
            total++;
            if (coeff_ready !== 1'b1) $display("FAIL ready_in_load got=%b want=1", coeff_ready);
            else passed++;
            total++;
            if (packed_coeffs !== exp_bus) $display("FAIL bus_stable_load got=%h want=%h", packed_coeffs, exp_bus);
            else passed++;
            tick();
            cyc++;
            if (v) k++;
        end
        coeff_valid = 1'b0;
        if (!hold_stb) sample_stb = 1'b0;
        if (k < ws.size()) begin
            total++;
            $display("FAIL load_timeout got=%0d want=%0d", k, ws.size());
        end
    endtask

    task automatic commit_after(input int delay, input logic [W*N-1:0] new_bus);
        int d0 = done_cnt;
        total++;
        if (coeff_ready !== 1'b0 || busy !== 1'b1) $display("FAIL commit_entry got=%b%b want=01", coeff_ready, busy);
        else passed++;
        for (int i = 0; i < delay; i++) begin
            sample_stb = 1'b0;
            tick();
            total++;
            if (packed_coeffs !== exp_bus || load_done !== 1'b0) $display("FAIL commit_wait got=%h want=%h", packed_coeffs, exp_bus);
            else passed++;
        end
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        exp_bus = new_bus;
        total++;
        if (packed_coeffs !== exp_bus) $display("FAIL commit_bus got=%h want=%h", packed_coeffs, exp_bus);
        else passed++;
        total++;
        if (load_done !== 1'b1) $display("FAIL load_done_pulse got=%b want=1", load_done);
        else passed++;
        tick();
        total++;
        if (load_done !== 1'b0 || busy !== 1'b0 || done_cnt != d0 + 1) $display("FAIL after_commit got=%b%b/%0d want=00/%0d", load_done, busy, done_cnt - d0, 1);
        else passed++;
    endtask

    function automatic void rand_words(output logic [W-1:0] ws[$]);
        ws = {};
        for (int k = 0; k < LC; k++) ws.push_back(W'($urandom));
    endfunction

    task automatic test_reset();
        total++;
        if (packed_coeffs !== RESET_BUS || busy !== 1'b0 || coeff_ready !== 1'b0 ||
            load_done !== 1'b0 || load_aborted !== 1'b0)
            $display("FAIL reset_state got=%h/%b%b want=%h/00", packed_coeffs, busy, coeff_ready, RESET_BUS);
        else passed++;
        sample_stb = 1'b1;
        tick();
        tick();
        sample_stb = 1'b0;
        total++;
        if (packed_coeffs !== RESET_BUS || load_done !== 1'b0) $display("FAIL stb_in_idle got=%h want=%h", packed_coeffs, RESET_BUS);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] all[$] = '{8'h10, 8'h20, 8'hF0, 8'h7F};
        logic [W-1:0] ws[$];
        ws = all[0:LC-1];
        do_start();
        load_words(ws, 0, 1'b0);
        commit_after(3, build_bus(ws));
`ifndef FIR_COEFF_SYMMETRIC_EN
        total++;
        if (packed_coeffs !== 32'h7FF02010) $display("FAIL spec_vector got=%h want=7ff02010", packed_coeffs);
        else passed++;
`endif
    endtask

    task automatic test_abort();
        logic [W-1:0] ws[$];
        logic [W-1:0] junk[$];
        int a0 = abort_cnt;
        rand_words(junk);
        ws = {};
        for (int k = 0; k < LC; k++) ws.push_back(W'(k + 1));
        do_start();
        load_words(junk[0:0], 0, 1'b0);
        start = 1'b1;
        coeff_valid = 1'b1;
        coeff_in = 8'hEE;
        tick();
        start = 1'b0;
        coeff_valid = 1'b0;
        total++;
        if (load_aborted !== 1'b1 || coeff_ready !== 1'b1 || busy !== 1'b1) $display("FAIL abort_pulse got=%b%b%b want=111", load_aborted, coeff_ready, busy);
        else passed++;
        load_words(ws, 0, 1'b0);
        commit_after(1, build_bus(ws));
        total++;
        if (abort_cnt != a0 + 1) $display("FAIL abort_count got=%0d want=1", abort_cnt - a0);
        else passed++;
    endtask

    task automatic test_toggle_valid();
        logic [W-1:0] ws[$];
        int a0 = abort_cnt;
        rand_words(ws);
        do_start();
        load_words(ws, 1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (coeff_ready !== 1'b0 || busy !== 1'b1 || packed_coeffs !== exp_bus || abort_cnt != a0)
            $display("FAIL start_in_commit got=%b%b %h want=01 %h", coeff_ready, busy, packed_coeffs, exp_bus);
        else passed++;
        commit_after(2, build_bus(ws));
    endtask

    task automatic test_stb_on_entry();
        logic [W-1:0] ws[$];
        rand_words(ws);
        do_start();
        load_words(ws, 0, 1'b1);
        total++;
        if (packed_coeffs !== exp_bus || load_done !== 1'b0) $display("FAIL min_commit_cycle got=%h want=%h", packed_coeffs, exp_bus);
        else passed++;
        commit_after(0, build_bus(ws));
    endtask

    task automatic test_reset_midload();
        logic [W-1:0] ws[$];
        rand_words(ws);
        do_start();
        load_words(ws[0:0], 0, 1'b0);
        #1 rst = 1'b1;
        #1;
        exp_bus = RESET_BUS;
        total++;
        if (packed_coeffs !== RESET_BUS || busy !== 1'b0 || coeff_ready !== 1'b0)
            $display("FAIL async_reset got=%h/%b%b want=%h/00", packed_coeffs, busy, coeff_ready, RESET_BUS);
        else passed++;
        tick();
        rst = 1'b0;
        tick();
        rand_words(ws);
        do_start();
        load_words(ws, 2, 1'b0);
        commit_after(1, build_bus(ws));
    endtask

    task automatic test_random();
        logic [W-1:0] ws[$];
        logic [W-1:0] junk[$];
        for (int it = 0; it < 10; it++) begin
            rand_words(ws);
            do_start();
            if ($urandom_range(0, 1) == 1) begin
                rand_words(junk);
                load_words(junk[0:$urandom_range(0, LC-2)], 2, 1'b0);
                do_start();
            end
            load_words(ws, 2, 1'b0);
            commit_after($urandom_range(0, 3), build_bus(ws));
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        coeff_in = '0;
        coeff_valid = 1'b0;
        sample_stb = 1'b0;
        exp_bus = RESET_BUS;
        tick();
        tick();
        rst = 1'b0;
        tick();
        test_reset();
        test_back_to_back();
        test_abort();
        test_toggle_valid();
        test_stb_on_entry();
        test_reset_midload();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
